alu_result_queue: RTL and testbench

ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

---
 rtl/alu_result_pkg.sv | 43 ++++
 rtl/alu_result_mux.sv | 54 +++++
 rtl/alu_result_queue.sv | 131 +++++++++++++
 tb/tb_alu_result_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_pkg
//  Description : Shared widths, op encoding and entry record for the ALU
//                result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_result_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 4;

    localparam logic [3:0] OP_P_FREDKIN  = 4'd0;
    localparam logic [3:0] OP_Q_FREDKIN  = 4'd1;
    localparam logic [3:0] OP_R_FREDKIN  = 4'd2;
    localparam logic [3:0] OP_P_PERES    = 4'd3;
    localparam logic [3:0] OP_Q_PERES    = 4'd4;
    localparam logic [3:0] OP_R_PERES    = 4'd5;
    localparam logic [3:0] OP_ADD        = 4'd6;
    localparam logic [3:0] OP_XOR        = 4'd7;
    localparam logic [3:0] OP_AND        = 4'd8;
    localparam logic [3:0] OP_OR         = 4'd9;
    localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

    // Per-entry side information; data is held separately so its width can
    // follow the queue's DATA_W parameter.
    typedef struct packed {
        logic [3:0] op;
        logic       zero;
        logic       err;
    } entry_tag_t;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] data;
        entry_tag_t                tag;
    } entry_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_mux.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_mux
//  Description : Selects one of ten ALU result buses by op and flags
//                zero / illegal-op.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_mux
    import alu_result_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] p_fredkin,
    input  logic [DATA_W-1:0] q_fredkin,
    input  logic [DATA_W-1:0] r_fredkin,
    input  logic [DATA_W-1:0] p_peres,
    input  logic [DATA_W-1:0] q_peres,
    input  logic [DATA_W-1:0] r_peres,
    input  logic [DATA_W-1:0] add_result,
    input  logic [DATA_W-1:0] xor_result,
    input  logic [DATA_W-1:0] and_result,
    input  logic [DATA_W-1:0] or_result,
    output logic [DATA_W-1:0] data,
    output logic              zero,
    output logic              err
);

    logic [DATA_W-1:0] w_sel;

    always_comb begin
        w_sel = '0;
        case (op)
            OP_P_FREDKIN: w_sel = p_fredkin;
            OP_Q_FREDKIN: w_sel = q_fredkin;
            OP_R_FREDKIN: w_sel = r_fredkin;
            OP_P_PERES:   w_sel = p_peres;
            OP_Q_PERES:   w_sel = q_peres;
            OP_R_PERES:   w_sel = r_peres;
            OP_ADD:       w_sel = add_result;
            OP_XOR:       w_sel = xor_result;
            OP_AND:       w_sel = and_result;
            OP_OR:        w_sel = or_result;
            default:      w_sel = '0;
        endcase
    end

    // An illegal op carries data 0 but must not be reported as a zero result.
    assign err  = !op_is_legal(op);
    assign data = w_sel;
    assign zero = !err && (w_sel == '0);

endmodule
`default_nettype wire

// File: rtl/alu_result_queue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_queue
//  Description : Circular FIFO of selected ALU results with op, zero and
//                illegal-op tags plus accept / error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_queue
    import alu_result_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [DATA_W-1:0]          p_fredkin,
    input  logic [DATA_W-1:0]          q_fredkin,
    input  logic [DATA_W-1:0]          r_fredkin,
    input  logic [DATA_W-1:0]          p_peres,
    input  logic [DATA_W-1:0]          q_peres,
    input  logic [DATA_W-1:0]          r_peres,
    input  logic [DATA_W-1:0]          add_result,
    input  logic [DATA_W-1:0]          xor_result,
    input  logic [DATA_W-1:0]          and_result,
    input  logic [DATA_W-1:0]          or_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [3:0]                 out_op,
    output logic                       out_zero,
    output logic                       out_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                accept_cnt,
    output logic [15:0]                err_cnt
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [DATA_W-1:0] r_data [DEPTH];
    entry_tag_t        r_tag  [DEPTH];

    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [15:0]       r_accept_cnt;
    logic [15:0]       r_err_cnt;

    logic [DATA_W-1:0] w_mux_data;
    logic              w_mux_zero;
    logic              w_mux_err;
    logic              w_push;
    logic              w_pop;
    entry_tag_t        w_head_tag;

    alu_result_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .op         (in_op),
        .p_fredkin  (p_fredkin),
        .q_fredkin  (q_fredkin),
        .r_fredkin  (r_fredkin),
        .p_peres    (p_peres),
        .q_peres    (q_peres),
        .r_peres    (r_peres),
        .add_result (add_result),
        .xor_result (xor_result),
        .and_result (and_result),
        .or_result  (or_result),
        .data       (w_mux_data),
        .zero       (w_mux_zero),
        .err        (w_mux_err)
    );

    // Handshake flags depend on registered occupancy only.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= w_mux_data;
            r_tag[r_wr_ptr]  <= '{op: in_op, zero: w_mux_zero, err: w_mux_err};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_accept_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + c_AW'(1);
                r_accept_cnt <= r_accept_cnt + 16'd1;
                if (w_mux_err && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_tag = r_tag[r_rd_ptr];

    assign out_data   = out_valid ? r_data[r_rd_ptr] : '0;
    assign out_op     = out_valid ? w_head_tag.op    : 4'd0;
    assign out_zero   = out_valid && w_head_tag.zero;
    assign out_err    = out_valid && w_head_tag.err;

    assign count      = r_count;
    assign accept_cnt = r_accept_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_queue
//  Description : Directed self-checking bench for alu_result_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] p_fredkin, q_fredkin, r_fredkin;
    logic [31:0] p_peres, q_peres, r_peres;
    logic [31:0] add_result, xor_result, and_result, or_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_op;
    logic        out_zero;
    logic        out_err;
    logic [2:0]  count;
    logic [15:0] accept_cnt;
    logic [15:0] err_cnt;

    int n_tests;
    int n_fail;

    logic [31:0] exp_q[$];

    alu_result_queue #(
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .p_fredkin  (p_fredkin),
        .q_fredkin  (q_fredkin),
        .r_fredkin  (r_fredkin),
        .p_peres    (p_peres),
        .q_peres    (q_peres),
        .r_peres    (r_peres),
        .add_result (add_result),
        .xor_result (xor_result),
        .and_result (and_result),
        .or_result  (or_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .count      (count),
        .accept_cnt (accept_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_table_buses();
        p_fredkin  = 32'h11; q_fredkin  = 32'h22; r_fredkin  = 32'h33;
        p_peres    = 32'h44; q_peres    = 32'h55; r_peres    = 32'h66;
        add_result = 32'h77; xor_result = 32'h88; and_result = 32'h99;
        or_result  = 32'hAA;
    endtask

    // Hand-written table matching the bus values above.
    function automatic logic [31:0] table_val(input logic [3:0] op);
        case (op)
            4'd0: return 32'h11;
            4'd1: return 32'h22;
            4'd2: return 32'h33;
            4'd3: return 32'h44;
            4'd4: return 32'h55;
            4'd5: return 32'h66;
            4'd6: return 32'h77;
            4'd7: return 32'h88;
            4'd8: return 32'h99;
            4'd9: return 32'hAA;
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        in_op   = 4'd0;
        set_table_buses();
        do_reset();

        // Reset state
        check("rst_count",     32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_accept",    32'(accept_cnt), 32'd0);
        check("rst_err_cnt",   32'(err_cnt), 32'd0);
        check("rst_out_data",  out_data, 32'd0);

        // Zero-valued add result; not visible in the push cycle itself
        add_result = 32'h0; in_op = 4'd6; in_valid = 1'b1;
        #1;
        check("no_bypass_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("add0_valid", 32'(out_valid), 32'd1);
        check("add0_data",  out_data, 32'h0);
        check("add0_zero",  32'(out_zero), 32'd1);
        check("add0_err",   32'(out_err), 32'd0);
        check("add0_op",    32'(out_op), 32'd6);
        check("add0_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("add0_drained", 32'(count), 32'd0);
        check("empty_data",   out_data, 32'd0);

        // xor all-ones then and zero, consumer always ready
        xor_result = 32'hFFFFFFFF; and_result = 32'h0;
        out_ready = 1'b1; in_valid = 1'b1; in_op = 4'd7;
        tick();
        check("xor_data", out_data, 32'hFFFFFFFF);
        check("xor_zero", 32'(out_zero), 32'd0);
        in_op = 4'd8;
        tick();
        in_valid = 1'b0;
        check("and_data",  out_data, 32'h0);
        check("and_zero",  32'(out_zero), 32'd1);
        check("and_op",    32'(out_op), 32'd8);
        check("and_count", 32'(count), 32'd1);
        tick();
        check("xa_drained", 32'(count), 32'd0);
        check("xa_accept",  32'(accept_cnt), 32'd3);

        // Fill to full with consumer stalled
        set_table_buses();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_op = 4'(i);
            tick();
        end
        check("full_count",    32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_op = 4'd4;
        tick();
        check("full_reject_count",  32'(count), 32'd4);
        check("full_reject_accept", 32'(accept_cnt), 32'd4);

        // Full queue, valid and ready together: only the pop happens
        out_ready = 1'b1;
        #1;
        check("full_head", out_data, 32'h11);
        tick();
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_ready", 32'(in_ready), 32'd1);
        check("full_pop_head",  out_data, 32'h22);
        check("full_pop_accept", 32'(accept_cnt), 32'd4);
        exp_q.delete();
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h33);
        exp_q.push_back(32'h44);

        // Ten cycles of simultaneous push and pop, wrapping both pointers
        for (int i = 0; i < 10; i++) begin
            in_op = 4'((5 + i) % 10);
            #1;
            check("stream_head", out_data, exp_q[0]);
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(table_val(4'((5 + i) % 10)));
            check("stream_count", 32'(count), 32'd3);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_head", out_data, exp_q[0]);
            void'(exp_q.pop_front());
            tick();
        end
        check("drain_count",  32'(count), 32'd0);
        check("drain_accept", 32'(accept_cnt), 32'd14);
        out_ready = 1'b0;

        // Illegal op: data 0, err set, zero clear
        do_reset();
        in_op = 4'd12; in_valid = 1'b1;
        tick();
        check("ill_data",    out_data, 32'h0);
        check("ill_err",     32'(out_err), 32'd1);
        check("ill_zero",    32'(out_zero), 32'd0);
        check("ill_op",      32'(out_op), 32'd12);
        check("ill_err_cnt", 32'(err_cnt), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i < 32'h10001; i++) begin
            tick();
        end
        in_valid = 1'b0;
        check("ill_err_sat",  32'(err_cnt), 32'hFFFF);
        check("ill_acc_wrap", 32'(accept_cnt), 32'd1);
        tick();
        check("ill_drained", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Reset mid-operation with a simultaneous push
        do_reset();
        in_op = 4'd3; in_valid = 1'b1;
        tick();
        tick();
        check("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("mid_rst_count",     32'(count), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready), 32'd1);
        check("mid_rst_accept",    32'(accept_cnt), 32'd0);
        check("mid_rst_data",      out_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
